// File: rtl/spec_ras_pkg.sv
// rtl/spec_ras_pkg.sv - op encodings and history-record sizing for spec_ras
package spec_ras_pkg;

  localparam logic [1:0] OP_NONE = 2'd0;
  localparam logic [1:0] OP_PUSH = 2'd1;
  localparam logic [1:0] OP_POP  = 2'd2;
  localparam logic [1:0] OP_REPL = 2'd3;

  function automatic logic [1:0] op_code(input logic push, input logic pop);
    return {pop, push};
  endfunction

  // record = {v, ptr, cnt, w, widx, wold}
  function automatic int rec_bits(input int xlen, input int depth);
    return 2 + 2 * $clog2(depth) + ($clog2(depth) + 1) + xlen;
  endfunction

endpackage

// File: rtl/spec_ras_hist_stage.sv
// rtl/spec_ras_hist_stage.sv - one speculative history register with shift/hold/clear
module spec_ras_hist_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         shift,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clear) q <= '0;
    else if (shift)   q <= d;
  end

endmodule

// File: rtl/spec_ras.sv
// rtl/spec_ras.sv - speculative return-address stack; rollback built when SPEC_RAS_ROLLBACK_EN is defined
module spec_ras
  import spec_ras_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8,
  parameter int HIST  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [XLEN-1:0]        push_data,
  input  logic                   stall,
  input  logic                   flush,
  output logic [XLEN-1:0]        top_data,
  output logic                   top_valid,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || HIST < 1) begin : g_bad_param
    $error("spec_ras: DEPTH must be a power of two >= 2 and HIST >= 1");
  end

  logic [XLEN-1:0] mem [DEPTH];
  logic [PW-1:0]   tp, tp_n, widx;
  logic [CW-1:0]   cnt_q, cnt_n;
  logic [1:0]      op;
  logic            empty, full, wen, ovf_n, unf_n;

  assign op    = (!stall && !flush) ? op_code(push, pop) : OP_NONE;
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));

  always_comb begin
    tp_n  = tp;
    cnt_n = cnt_q;
    widx  = tp;
    wen   = 1'b0;
    ovf_n = 1'b0;
    unf_n = 1'b0;
    case (op)
      OP_PUSH: begin
        tp_n  = tp + 1'b1;
        widx  = tp + 1'b1;
        wen   = 1'b1;
        cnt_n = full ? cnt_q : cnt_q + 1'b1;
        ovf_n = full;
      end
      OP_POP: begin
        if (empty) unf_n = 1'b1;
        else begin
          tp_n  = tp - 1'b1;
          cnt_n = cnt_q - 1'b1;
        end
      end
      OP_REPL: begin
        wen = 1'b1;
        // replace on an empty stack degrades to a push but still flags underflow
        if (empty) begin
          tp_n  = tp + 1'b1;
          widx  = tp + 1'b1;
          cnt_n = CW'(1);
          unf_n = 1'b1;
        end
      end
      default: ;
    endcase
  end

`ifdef SPEC_RAS_ROLLBACK_EN
  localparam int RW     = rec_bits(XLEN, DEPTH);
  localparam int O_WIDX = XLEN;
  localparam int O_W    = XLEN + PW;
  localparam int O_CNT  = O_W + 1;
  localparam int O_PTR  = O_CNT + CW;
  localparam int O_V    = O_PTR + PW;

  logic [HIST-1:0][RW-1:0] hq, hd;
  logic [RW-1:0]           rec_new;
  logic                    rb_any;
  logic [PW-1:0]           rb_tp;
  logic [CW-1:0]           rb_cnt;

  assign rec_new = {op != OP_NONE, tp, cnt_q, wen, widx, mem[widx]};

  for (genvar k = 0; k < HIST; k++) begin : g_hist
    if (k == 0) begin : g_head
      assign hd[k] = rec_new;
    end else begin : g_tail
      assign hd[k] = hq[k-1];
    end
    spec_ras_hist_stage #(.W(RW)) u_stage (
      .clk   (clk),
      .rst   (rst),
      .shift (!stall && !flush),
      .clear (flush),
      .d     (hd[k]),
      .q     (hq[k])
    );
  end

  // the oldest valid stage holds the pre-speculation pointer and count
  always_comb begin
    rb_any = 1'b0;
    rb_tp  = tp;
    rb_cnt = cnt_q;
    for (int k = 0; k < HIST; k++) begin
      if (hq[k][O_V]) begin
        rb_any = 1'b1;
        rb_tp  = hq[k][O_PTR +: PW];
        rb_cnt = hq[k][O_CNT +: CW];
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      tp        <= '0;
      cnt_q     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else begin
      overflow  <= ovf_n;
      underflow <= unf_n;
      tp        <= tp_n;
      cnt_q     <= cnt_n;
      if (wen) mem[widx] <= push_data;
`ifdef SPEC_RAS_ROLLBACK_EN
      if (flush) begin
        if (rb_any) begin
          tp    <= rb_tp;
          cnt_q <= rb_cnt;
        end
        // youngest to oldest so the oldest restore of a shared slot lands last
        for (int k = 0; k < HIST; k++) begin
          if (hq[k][O_V] && hq[k][O_W]) mem[hq[k][O_WIDX +: PW]] <= hq[k][XLEN-1:0];
        end
      end
`endif
    end
  end

  assign top_data  = mem[tp];
  assign top_valid = (cnt_q != '0);
  assign count     = cnt_q;

endmodule

// File: tb/tb_spec_ras.sv
// tb/tb_spec_ras.sv - directed self-checking bench for spec_ras (DEPTH=4, HIST=2)
module tb_spec_ras;

  logic        clk = 1'b0;
  logic        rst, push, pop, stall, flush;
  logic [31:0] push_data;
  logic [31:0] top_data;
  logic        top_valid, overflow, underflow;
  logic [2:0]  count;
  int          total = 0;
  int          bad   = 0;

`ifdef SPEC_RAS_ROLLBACK_EN
  localparam logic [31:0] T3_TOP = 32'hB;
  localparam logic [31:0] T4_TOP = 32'hB;
`else
  localparam logic [31:0] T3_TOP = 32'hC;
  localparam logic [31:0] T4_TOP = 32'hD;
`endif

  spec_ras #(.XLEN(32), .DEPTH(4), .HIST(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (push_data),
    .stall     (stall),
    .flush     (flush),
    .top_data  (top_data),
    .top_valid (top_valid),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic p, input logic q, input logic [31:0] d,
                      input logic s, input logic f, input logic r = 1'b0);
    push = p; pop = q; push_data = d; stall = s; flush = f; rst = r;
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0; stall = 1'b0; flush = 1'b0; rst = 1'b0;
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
  endtask

  task automatic do_push(input logic [31:0] d); step(1, 0, d, 0, 0); endtask
  task automatic do_pop();                      step(0, 1, 0, 0, 0); endtask
  task automatic idle();                        step(0, 0, 0, 0, 0); endtask

  logic [31:0] exp_pop [4];

  initial begin
    push = 0; pop = 0; stall = 0; flush = 0; push_data = 0; rst = 1;
    do_reset();
    chk("rst_top", top_data, 0);
    chk("rst_valid", {31'd0, top_valid}, 0);
    chk("rst_count", {29'd0, count}, 0);
    chk("rst_ovf", {31'd0, overflow}, 0);
    chk("rst_unf", {31'd0, underflow}, 0);

    // 1: basic push/pop
    do_push(32'h100); do_push(32'h200); do_push(32'h300);
    chk("t1_top3", top_data, 32'h300);
    chk("t1_cnt3", {29'd0, count}, 3);
    do_pop(); do_pop();
    chk("t1_top", top_data, 32'h100);
    chk("t1_cnt1", {29'd0, count}, 1);
    do_pop();
    chk("t1_cnt0", {29'd0, count}, 0);
    chk("t1_valid0", {31'd0, top_valid}, 0);

    // 2: overflow wraps over oldest entry
    do_reset();
    do_push(32'h10); do_push(32'h20); do_push(32'h30); do_push(32'h40);
    chk("t2_ovf_quiet", {31'd0, overflow}, 0);
    chk("t2_cnt4", {29'd0, count}, 4);
    do_push(32'h50);
    chk("t2_ovf", {31'd0, overflow}, 1);
    chk("t2_cnt_sat", {29'd0, count}, 4);
    chk("t2_top", top_data, 32'h50);
    idle();
    chk("t2_ovf_pulse", {31'd0, overflow}, 0);
    exp_pop[0] = 32'h50; exp_pop[1] = 32'h40; exp_pop[2] = 32'h30; exp_pop[3] = 32'h20;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_pop%0d", i), top_data, exp_pop[i]);
      do_pop();
    end
    chk("t2_cnt_end", {29'd0, count}, 0);

    // 3: pop then push, flushed
    do_reset();
    do_push(32'hA); do_push(32'hB); idle(); idle();
    do_pop(); do_push(32'hC);
    step(0, 0, 0, 0, 1);
    chk("t3_top", top_data, T3_TOP);
    chk("t3_cnt", {29'd0, count}, 2);
    do_pop();
    chk("t3_below", top_data, 32'hA);

    // 4: replace, flushed
    do_reset();
    do_push(32'hA); do_push(32'hB); idle(); idle();
    step(1, 1, 32'hD, 0, 0);
    chk("t4_repl_top", top_data, 32'hD);
    chk("t4_repl_cnt", {29'd0, count}, 2);
    chk("t4_repl_unf", {31'd0, underflow}, 0);
    step(0, 0, 0, 0, 1);
    chk("t4_flush_top", top_data, T4_TOP);
    chk("t4_flush_cnt", {29'd0, count}, 2);

    // 5: stalled push never lands; committed push survives flush
    do_reset();
    do_push(32'h7); idle(); idle();
    for (int i = 0; i < 3; i++) step(1, 0, 32'h1, 1, 0);
    chk("t5_stall_cnt", {29'd0, count}, 1);
    step(0, 0, 0, 0, 1);
    chk("t5_top", top_data, 32'h7);
    chk("t5_cnt", {29'd0, count}, 1);
    do_push(32'h2); idle(); idle();
    step(0, 0, 0, 0, 1);
    chk("t5_commit_top", top_data, 32'h2);
    chk("t5_commit_cnt", {29'd0, count}, 2);

    // 6: underflow, replace on empty, reset during flush
    do_reset();
    do_pop();
    chk("t6_unf", {31'd0, underflow}, 1);
    chk("t6_cnt", {29'd0, count}, 0);
    idle();
    chk("t6_unf_pulse", {31'd0, underflow}, 0);
    step(1, 1, 32'h9, 0, 0);
    chk("t6_repl_unf", {31'd0, underflow}, 1);
    chk("t6_repl_cnt", {29'd0, count}, 1);
    chk("t6_repl_top", top_data, 32'h9);
    do_push(32'h5);
    step(0, 0, 0, 0, 1, 1);
    chk("t6_rst_top", top_data, 0);
    chk("t6_rst_cnt", {29'd0, count}, 0);
    chk("t6_rst_valid", {31'd0, top_valid}, 0);
    chk("t6_rst_flags", {30'd0, overflow, underflow}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
